// File: rtl/keyrec_pkg.sv
// Shared definitions for the keypad record/replay blocks: controller states,
// the right-numpad scan-code table and the blank-display digit value.
package keyrec_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      SHOW   = 2'd2
   } state_t;

   localparam int NUM_KEYS = 10;

   // {extended bit, scan code} for numpad digits 0..9, indexed by digit value.
   localparam logic [8:0] KEY_CODES [0:NUM_KEYS-1] = '{
      9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
      9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D
   };

   // Digit value driven whenever the display is blanked (matches reset value).
   localparam logic [3:0] DIGIT_NONE = 4'h0;

endpackage

// File: rtl/keycode_to_digit.sv
// Combinational lookup of a 9-bit {extended, scan code} against the numpad
// digit table. hit is 1 only for a non-extended table code.
module keycode_to_digit
   import keyrec_pkg::*;
(
   input  logic [8:0] key_code,
   output logic       hit,
   output logic [3:0] digit
);

   // Linear table search; the extended bit is part of each table entry.
   always_comb begin
      hit   = 1'b0;
      digit = DIGIT_NONE;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (key_code == KEY_CODES[i]) begin
            hit   = 1'b1;
            digit = 4'(i);
         end
      end
   end

endmodule

// File: rtl/key_sequence_recorder.sv
// Records numpad digit presses into a DEPTH-entry buffer and replays them,
// one entry per PLAY_TICKS cycles, toward the 7-segment driver.
module key_sequence_recorder
   import keyrec_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int PLAY_TICKS = 50_000_000,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic             key_make,
   input  logic [8:0]       key_code,
   input  logic             record_btn,
   input  logic             show_btn,
   output logic [3:0]       digit_val,
   output logic             digit_blank,
   output logic [CNT_W-1:0] count,
   output logic [DEPTH-1:0] led,
   output logic             overflow,
   output logic             busy
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int TICK_W = (PLAY_TICKS > 1) ? $clog2(PLAY_TICKS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PLAY_TICKS - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [3:0]        digit_val_q, digit_val_d;
   logic              digit_blank_q, digit_blank_d;

   logic [3:0]        mem [0:DEPTH-1];
   logic              wr_en;
   logic [IDX_W-1:0]  wr_addr;
   logic [IDX_W-1:0]  idx_inc;
   logic              last_entry;

   logic              key_hit;
   logic [3:0]        key_digit;
   logic              key_press;

   keycode_to_digit u_keycode_to_digit (
      .key_code (key_code),
      .hit      (key_hit),
      .digit    (key_digit)
   );

   assign key_press  = key_valid & key_make & key_hit;
   assign wr_addr    = count_q[IDX_W-1:0];
   assign idx_inc    = idx_q + 1'b1;
   assign last_entry = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));

   // Next-state, buffer-write and display decisions; record_btn has priority.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      overflow_d    = overflow_q;
      idx_d         = idx_q;
      tick_d        = tick_q;
      digit_val_d   = digit_val_q;
      digit_blank_d = digit_blank_q;
      wr_en         = 1'b0;

      case (state_q)
         IDLE: begin
            if (record_btn) begin
               state_d       = RECORD;
               count_d       = '0;
               overflow_d    = 1'b0;
               digit_val_d   = DIGIT_NONE;
               digit_blank_d = 1'b1;
            end else if (show_btn && (count_q != '0)) begin
               state_d       = SHOW;
               idx_d         = '0;
               tick_d        = '0;
               digit_val_d   = mem[0];
               digit_blank_d = 1'b0;
            end
         end

         RECORD: begin
            if (record_btn) begin
               state_d       = IDLE;
               digit_val_d   = DIGIT_NONE;
               digit_blank_d = 1'b1;
            end else if (key_press) begin
               if (count_q == CNT_FULL) begin
                  overflow_d = 1'b1;
               end else begin
                  wr_en         = 1'b1;
                  count_d       = count_q + CNT_W'(1);
                  digit_val_d   = key_digit;
                  digit_blank_d = 1'b0;
               end
            end
         end

         SHOW: begin
            if (record_btn) begin
               state_d       = IDLE;
               digit_val_d   = DIGIT_NONE;
               digit_blank_d = 1'b1;
            end else if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (last_entry) begin
                  state_d       = IDLE;
                  digit_val_d   = DIGIT_NONE;
                  digit_blank_d = 1'b1;
               end else begin
                  idx_d       = idx_inc;
                  digit_val_d = mem[idx_inc];
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end

         default: begin
            state_d       = IDLE;
            digit_val_d   = DIGIT_NONE;
            digit_blank_d = 1'b1;
         end
      endcase
   end

   // Control and display registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         idx_q         <= '0;
         tick_q        <= '0;
         digit_val_q   <= DIGIT_NONE;
         digit_blank_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         idx_q         <= idx_d;
         tick_q        <= tick_d;
         digit_val_q   <= digit_val_d;
         digit_blank_q <= digit_blank_d;
      end
   end

   // Digit buffer; contents survive reset and are simply overwritten on record.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= key_digit;
      end
   end

   // Occupancy thermometer: bit gi is lit once more than gi entries are stored.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_led
         assign led[gi] = (count_q > CNT_W'(gi));
      end
   endgenerate

   assign digit_val   = digit_val_q;
   assign digit_blank = digit_blank_q;
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign busy        = (state_q == SHOW);

endmodule

// File: tb/tb_key_sequence_recorder.sv
// Directed-vector bench for key_sequence_recorder with DEPTH=4, PLAY_TICKS=4.
module tb_key_sequence_recorder;

   localparam int DEPTH      = 4;
   localparam int PLAY_TICKS = 4;
   localparam int CNT_W      = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             key_valid = 1'b0;
   logic             key_make = 1'b0;
   logic [8:0]       key_code = '0;
   logic             record_btn = 1'b0;
   logic             show_btn = 1'b0;
   logic [3:0]       digit_val;
   logic             digit_blank;
   logic [CNT_W-1:0] count;
   logic [DEPTH-1:0] led;
   logic             overflow;
   logic             busy;

   int vectors     = 0;
   int miscompares = 0;

   key_sequence_recorder #(
      .DEPTH      (DEPTH),
      .PLAY_TICKS (PLAY_TICKS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_make    (key_make),
      .key_code    (key_code),
      .record_btn  (record_btn),
      .show_btn    (show_btn),
      .digit_val   (digit_val),
      .digit_blank (digit_blank),
      .count       (count),
      .led         (led),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Advance one edge; inputs driven before the call are sampled on it, and
   // outputs are read 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_rec();
      record_btn = 1'b1;
      step();
      record_btn = 1'b0;
   endtask

   task automatic press_show();
      show_btn = 1'b1;
      step();
      show_btn = 1'b0;
   endtask

   task automatic key(input logic make, input logic [8:0] code);
      key_valid = 1'b1;
      key_make  = make;
      key_code  = code;
      step();
      key_valid = 1'b0;
      key_make  = 1'b0;
      key_code  = '0;
   endtask

   task automatic check_reset_vals(input string tag);
      check_vec({tag, ".count"},    32'(count),       32'd0);
      check_vec({tag, ".digit"},    32'(digit_val),   32'd0);
      check_vec({tag, ".blank"},    32'(digit_blank), 32'd1);
      check_vec({tag, ".led"},      32'(led),         32'd0);
      check_vec({tag, ".overflow"}, 32'(overflow),    32'd0);
      check_vec({tag, ".busy"},     32'(busy),        32'd0);
   endtask

   logic [3:0] seq_a [0:2];
   logic [3:0] seq_b [0:3];

   initial begin
      seq_a[0] = 4'd1; seq_a[1] = 4'd2; seq_a[2] = 4'd0;
      seq_b[0] = 4'd1; seq_b[1] = 4'd2; seq_b[2] = 4'd3; seq_b[3] = 4'd4;

      #2;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check_reset_vals("reset");

      // 1. Record 1, 2, 0
      press_rec();
      check_vec("rec_entry.count", 32'(count), 32'd0);
      check_vec("rec_entry.blank", 32'(digit_blank), 32'd1);
      key(1'b1, 9'h069);
      check_vec("store1.count", 32'(count), 32'd1);
      check_vec("store1.digit", 32'(digit_val), 32'd1);
      check_vec("store1.blank", 32'(digit_blank), 32'd0);
      key(1'b1, 9'h072);
      check_vec("store2.digit", 32'(digit_val), 32'd2);
      key(1'b1, 9'h070);
      check_vec("store3.count", 32'(count), 32'd3);
      check_vec("store3.led", 32'(led), 32'b0111);
      check_vec("store3.digit", 32'(digit_val), 32'd0);
      check_vec("store3.overflow", 32'(overflow), 32'd0);

      // 2. Ignored events in RECORD
      key(1'b0, 9'h069);
      check_vec("break.count", 32'(count), 32'd3);
      key(1'b1, 9'h01C);
      check_vec("nontable.count", 32'(count), 32'd3);
      key(1'b1, 9'h170);
      check_vec("extended.count", 32'(count), 32'd3);
      check_vec("extended.digit", 32'(digit_val), 32'd0);

      // 4. Replay 1, 2, 0 for PLAY_TICKS cycles each
      press_rec();
      check_vec("idle.busy", 32'(busy), 32'd0);
      press_show();
      for (int k = 1; k <= 3 * PLAY_TICKS; k++) begin
         if (k > 1) step();
         check_vec($sformatf("play_a[%0d].digit", k), 32'(digit_val), 32'(seq_a[(k - 1) / PLAY_TICKS]));
         check_vec($sformatf("play_a[%0d].busy", k), 32'(busy), 32'd1);
      end
      check_vec("play_a.blank_during", 32'(digit_blank), 32'd0);
      step();
      check_vec("play_a_end.busy", 32'(busy), 32'd0);
      check_vec("play_a_end.blank", 32'(digit_blank), 32'd1);
      check_vec("play_a_end.count", 32'(count), 32'd3);

      // 5. Abort replay, then simultaneous buttons
      press_show();
      step();
      check_vec("abort_pre.busy", 32'(busy), 32'd1);
      press_rec();
      check_vec("abort.busy", 32'(busy), 32'd0);
      check_vec("abort.blank", 32'(digit_blank), 32'd1);
      check_vec("abort.count", 32'(count), 32'd3);
      record_btn = 1'b1;
      show_btn   = 1'b1;
      step();
      record_btn = 1'b0;
      show_btn   = 1'b0;
      check_vec("both.count", 32'(count), 32'd0);
      check_vec("both.busy", 32'(busy), 32'd0);
      key(1'b1, 9'h07D);
      check_vec("both_rec.count", 32'(count), 32'd1);
      check_vec("both_rec.digit", 32'(digit_val), 32'd9);

      // 3. Overflow: restart recording, store 1..4, then a fifth press
      press_rec();
      press_rec();
      check_vec("rerec.count", 32'(count), 32'd0);
      key(1'b1, 9'h069);
      key(1'b1, 9'h072);
      key(1'b1, 9'h07A);
      key(1'b1, 9'h06B);
      check_vec("full.count", 32'(count), 32'd4);
      check_vec("full.led", 32'(led), 32'b1111);
      check_vec("full.overflow", 32'(overflow), 32'd0);
      key(1'b1, 9'h073);
      check_vec("ovf.count", 32'(count), 32'd4);
      check_vec("ovf.overflow", 32'(overflow), 32'd1);
      check_vec("ovf.digit", 32'(digit_val), 32'd4);
      press_rec();
      check_vec("ovf_idle.overflow", 32'(overflow), 32'd1);
      press_show();
      for (int k = 1; k <= 4 * PLAY_TICKS; k++) begin
         if (k > 1) step();
         if (((k - 1) % PLAY_TICKS) == 0)
            check_vec($sformatf("play_b[%0d].digit", k), 32'(digit_val), 32'(seq_b[(k - 1) / PLAY_TICKS]));
      end
      step();
      check_vec("play_b_end.busy", 32'(busy), 32'd0);

      // 6. rst during SHOW, then show_btn with empty buffer
      press_show();
      step();
      check_vec("rst_pre.busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_vals("rst_show");
      press_show();
      check_vec("empty_show.busy", 32'(busy), 32'd0);
      check_vec("empty_show.blank", 32'(digit_blank), 32'd1);
      step();
      check_vec("empty_show2.busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
